laundry_pay_ctrl: RTL

Payment and session controller that drives the washing-machine FSM from the customer side. It accumulates coin credit, prices single or double wash, issues the one-cycle coin-deposit pulse and the double-wash select to the washer, forwards customer abort as the spin interrupt, and returns change or unused credit. It watches the washer's done/interrupt outputs with a watchdog and latches a fault if the washer never reports completion.

---
 rtl/laundry_pay_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/laundry_pay_ctrl.sv
// Customer-side payment/session controller for the washing-machine FSM:
// coin credit, pricing, launch pulse, abort forwarding, refunds and a run watchdog.
module laundry_pay_ctrl #(
  parameter int unsigned PRICE_SINGLE = 4,
  parameter int unsigned PRICE_DOUBLE = 6,
  parameter int unsigned CREDIT_W     = 4,
  parameter int unsigned IDLE_TIMEOUT = 15,
  parameter int unsigned RUN_TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid_i,
  input  logic [2:0]          coin_val_i,
  input  logic                sel_double_i,
  input  logic                start_i,
  input  logic                cancel_i,
  input  logic                abort_i,
  input  logic                done_i,
  input  logic                off_interrupt_i,
  output logic                coin_deposit_o,
  output logic                double_wash_o,
  output logic                spin_interrupt_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                refund_valid_o,
  output logic [CREDIT_W-1:0] refund_amt_o,
  output logic                coin_reject_o,
  output logic                start_reject_o,
  output logic                busy_o,
  output logic                session_done_o,
  output logic                interrupted_o,
  output logic                fault_o
);

  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned RW = $clog2(RUN_TIMEOUT + 1);
  localparam logic [CREDIT_W-1:0] P_SINGLE   = CREDIT_W'(PRICE_SINGLE);
  localparam logic [CREDIT_W-1:0] P_DOUBLE   = CREDIT_W'(PRICE_DOUBLE);
  localparam logic [CREDIT_W:0]   CREDIT_MAX = (CREDIT_W + 1)'((1 << CREDIT_W) - 1);
  localparam logic [IW-1:0]       IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);
  localparam logic [RW-1:0]       RUN_LAST   = RW'(RUN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CREDIT, S_LAUNCH, S_RUN, S_FINISH, S_REFUND, S_FAULT
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [IW-1:0]       idle_q, idle_d;
  logic [RW-1:0]       run_q, run_d;
  logic                dbl_q, dbl_d;
  logic                spin_q, spin_d;
  logic                dep_q, dep_d;
  logic                rv_q, rv_d;
  logic [CREDIT_W-1:0] ramt_q, ramt_d;
  logic                crej_q, crej_d;
  logic                srej_q, srej_d;
  logic                busy_q, busy_d;
  logic                sdone_q, sdone_d;
  logic                intr_q, intr_d;
  logic                fault_q, fault_d;

  logic [CREDIT_W:0]   sum;
  logic                coin_ok;
  logic [CREDIT_W-1:0] price;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      idle_q   <= '0;
      run_q    <= '0;
      dbl_q    <= 1'b0;
      spin_q   <= 1'b0;
      dep_q    <= 1'b0;
      rv_q     <= 1'b0;
      ramt_q   <= '0;
      crej_q   <= 1'b0;
      srej_q   <= 1'b0;
      busy_q   <= 1'b0;
      sdone_q  <= 1'b0;
      intr_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      idle_q   <= idle_d;
      run_q    <= run_d;
      dbl_q    <= dbl_d;
      spin_q   <= spin_d;
      dep_q    <= dep_d;
      rv_q     <= rv_d;
      ramt_q   <= ramt_d;
      crej_q   <= crej_d;
      srej_q   <= srej_d;
      busy_q   <= busy_d;
      sdone_q  <= sdone_d;
      intr_q   <= intr_d;
      fault_q  <= fault_d;
    end
  end

  // Pulses and refund data are computed on the transition into the state that
  // shows them, so every output comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    idle_d   = idle_q;
    run_d    = run_q;
    dbl_d    = dbl_q;
    spin_d   = spin_q;
    dep_d    = 1'b0;
    rv_d     = 1'b0;
    ramt_d   = '0;
    crej_d   = 1'b0;
    srej_d   = 1'b0;
    sdone_d  = 1'b0;
    intr_d   = 1'b0;
    sum      = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_val_i);
    coin_ok  = (coin_val_i != 3'd0) && (sum <= CREDIT_MAX);
    price    = sel_double_i ? P_DOUBLE : P_SINGLE;

    case (state_q)
      S_IDLE: begin
        if (start_i) srej_d = 1'b1;
        if (coin_valid_i) begin
          if (coin_ok) begin
            credit_d = sum[CREDIT_W-1:0];
            idle_d   = '0;
            state_d  = S_CREDIT;
          end else begin
            crej_d = 1'b1;
          end
        end
      end
      S_CREDIT: begin
        if (cancel_i) begin
          crej_d   = coin_valid_i;
          rv_d     = 1'b1;
          ramt_d   = credit_q;
          credit_d = '0;
          state_d  = S_REFUND;
        end else if (start_i && (credit_q >= price)) begin
          crej_d   = coin_valid_i;
          dep_d    = 1'b1;
          dbl_d    = sel_double_i;
          rv_d     = (credit_q != price);
          ramt_d   = (credit_q != price) ? credit_q - price : '0;
          credit_d = '0;
          state_d  = S_LAUNCH;
        end else begin
          srej_d = start_i;
          if (coin_valid_i) begin
            if (coin_ok) credit_d = sum[CREDIT_W-1:0];
            else         crej_d   = 1'b1;
          end
          if (start_i || coin_valid_i) begin
            idle_d = '0;
          end else if (idle_q == IDLE_LAST) begin
            rv_d     = 1'b1;
            ramt_d   = credit_q;
            credit_d = '0;
            state_d  = S_REFUND;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        crej_d  = coin_valid_i;
        run_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        crej_d = coin_valid_i;
        if (off_interrupt_i || done_i) begin
          intr_d  = off_interrupt_i;
          sdone_d = !off_interrupt_i;
          dbl_d   = 1'b0;
          spin_d  = 1'b0;
          state_d = S_FINISH;
        end else if (run_q == RUN_LAST) begin
          dbl_d   = 1'b0;
          spin_d  = 1'b0;
          state_d = S_FAULT;
        end else begin
          run_d = run_q + 1'b1;
          if (abort_i) spin_d = 1'b1;
        end
      end
      S_FINISH: begin
        crej_d  = coin_valid_i;
        state_d = S_IDLE;
      end
      S_REFUND: begin
        crej_d  = coin_valid_i;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        crej_d = coin_valid_i;
        srej_d = start_i;
        dbl_d  = 1'b0;
        spin_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d == S_LAUNCH) || (state_d == S_RUN);
    fault_d = (state_d == S_FAULT);
  end

  assign coin_deposit_o   = dep_q;
  assign double_wash_o    = dbl_q;
  assign spin_interrupt_o = spin_q;
  assign credit_o         = credit_q;
  assign refund_valid_o   = rv_q;
  assign refund_amt_o     = ramt_q;
  assign coin_reject_o    = crej_q;
  assign start_reject_o   = srej_q;
  assign busy_o           = busy_q;
  assign session_done_o   = sdone_q;
  assign interrupted_o    = intr_q;
  assign fault_o          = fault_q;

endmodule
